// File: rtl/pwm_capture.sv
// PWM period / high-time capture with timeout supervision.
// Optional glitch filter enabled by defining PWM_CAP_GLITCH_FILTER_EN.
`timescale 1ns/1ps

module pwm_capture #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 32'd65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             level
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             q_s;
    logic             q_prev_q, q_prev_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] hi_tmp_q, hi_tmp_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    // Synchroniser and registered edge detection (one stage after the synchroniser).
    always_comb begin
        sync1_d  = pwm_in;
        sync2_d  = sync1_q;
        q_prev_d = q_s;
        rise_d   = q_s & ~q_prev_q;
        fall_d   = ~q_s & q_prev_q;
    end

`ifdef PWM_CAP_GLITCH_FILTER_EN
    logic hist1_q, hist1_d;
    logic hist2_q, hist2_d;
    logic held_q, held_d;

    // Qualified level follows the synchroniser only after three identical samples.
    always_comb begin
        hist1_d = sync2_q;
        hist2_d = hist1_q;
        if ((sync2_q == hist1_q) && (hist1_q == hist2_q)) begin
            q_s = sync2_q;
        end else begin
            q_s = held_q;
        end
        held_d = q_s;
    end

    // Filter history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            hist1_q <= hist1_d;
            hist2_q <= hist2_d;
            held_q  <= held_d;
        end
    end
`else
    // Without the filter the qualified level is the synchroniser output.
    always_comb begin
        q_s = sync2_q;
    end
`endif

    // Counter saturates at TIMEOUT so it can never wrap, even when an edge wins at the limit.
    always_comb begin
        if (cnt_q == TIMEOUT_C) begin
            cnt_inc_s = cnt_q;
        end else begin
            cnt_inc_s = cnt_q + ONE_C;
        end
    end

    // Measurement FSM: next state, counter and result registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_tmp_d    = hi_tmp_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;
        if (!ena) begin
            state_d = ST_SYNC;
            cnt_d   = ZERO_C;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    if (rise_q) begin
                        state_d = ST_HIGH;
                        cnt_d   = ONE_C;
                    end else begin
                        state_d = ST_SYNC;
                    end
                end
                ST_HIGH: begin
                    if (fall_q) begin
                        state_d  = ST_LOW;
                        hi_tmp_d = cnt_q;
                        cnt_d    = cnt_inc_s;
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_d   = ST_SYNC;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                ST_LOW: begin
                    if (rise_q) begin
                        state_d     = ST_HIGH;
                        period_d    = cnt_q;
                        high_time_d = hi_tmp_q;
                        valid_d     = 1'b1;
                        timeout_d   = 1'b0;
                        cnt_d       = ONE_C;
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_d   = ST_SYNC;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                default: begin
                    state_d = ST_SYNC;
                    cnt_d   = ZERO_C;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            q_prev_q    <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            state_q     <= ST_SYNC;
            cnt_q       <= ZERO_C;
            hi_tmp_q    <= ZERO_C;
            period_q    <= ZERO_C;
            high_time_q <= ZERO_C;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            q_prev_q    <= q_prev_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_tmp_q    <= hi_tmp_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign level     = q_prev_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table-driven waveforms plus corner-case sequences,
// with a scoreboard queue of expected measurements per instance.
`timescale 1ns/1ps

module tb_pwm_capture;

`ifdef PWM_CAP_GLITCH_FILTER_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 4;
`endif

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        pwm_a;
    logic        pwm_b;
    logic [15:0] period_a;
    logic [15:0] high_time_a;
    logic        valid_a;
    logic        timeout_a;
    logic        level_a;
    logic [3:0]  period_b;
    logic [3:0]  high_time_b;
    logic        valid_b;
    logic        timeout_b;
    logic        level_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int hi;
        int lo;
        int n;
        int exp_period;
        int exp_high;
    } vec_t;

    typedef struct {
        int period;
        int high;
    } exp_t;

    vec_t vecs[5];
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea;
    exp_t eb;

    pwm_capture #(.CNT_W(16), .TIMEOUT(20)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pwm_in(pwm_a),
        .period(period_a), .high_time(high_time_a), .valid(valid_a),
        .timeout(timeout_a), .level(level_a)
    );

    pwm_capture #(.CNT_W(4), .TIMEOUT(15)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pwm_in(pwm_b),
        .period(period_b), .high_time(high_time_b), .valid(valid_b),
        .timeout(timeout_b), .level(level_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_period(input int sel, input int hi, input int lo);
        if (sel == 0) pwm_a = 1'b1; else pwm_b = 1'b1;
        cyc(hi);
        if (sel == 0) pwm_a = 1'b0; else pwm_b = 1'b0;
        cyc(lo);
    endtask

    // n measured periods on dut_a: n+1 rises, first one only arms the FSM.
    task automatic run_wave(input int hi, input int lo, input int n, input int ep, input int eh);
        exp_t e;
        e.period = ep;
        e.high   = eh;
        for (int i = 0; i < n; i++) q_a.push_back(e);
        for (int i = 0; i < n; i++) drive_period(0, hi, lo);
        pwm_a = 1'b1;
        cyc(hi);
        pwm_a = 1'b0;
        cyc(10);
    endtask

    task automatic restart();
        ena = 1'b0;
        cyc(3);
        ena = 1'b1;
        cyc(2);
    endtask

    initial begin
        int lat_k;

        vecs[0] = '{hi: 3,  lo: 7, n: 3, exp_period: 10, exp_high: 3};
        vecs[1] = '{hi: 4,  lo: 4, n: 3, exp_period: 8,  exp_high: 4};
        vecs[2] = '{hi: 10, lo: 3, n: 3, exp_period: 13, exp_high: 10};
        vecs[3] = '{hi: 6,  lo: 9, n: 3, exp_period: 15, exp_high: 6};
        vecs[4] = '{hi: 3,  lo: 3, n: 3, exp_period: 6,  exp_high: 3};

        rst_n = 1'b0;
        ena   = 1'b0;
        pwm_a = 1'b0;
        pwm_b = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (valid_a === 1'b1) begin
                    if (q_a.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_valid_a actual=1 expected=0");
                    end else begin
                        ea = q_a.pop_front();
                        check("period_a", int'(period_a), ea.period);
                        check("high_time_a", int'(high_time_a), ea.high);
                        check("timeout_at_valid_a", int'(timeout_a), 0);
                    end
                end
                if (valid_b === 1'b1) begin
                    if (q_b.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_valid_b actual=1 expected=0");
                    end else begin
                        eb = q_b.pop_front();
                        check("period_b", int'(period_b), eb.period);
                        check("high_time_b", int'(high_time_b), eb.high);
                        check("timeout_at_valid_b", int'(timeout_b), 0);
                    end
                end
            end
        join_none

        // Reset values.
        cyc(3);
        check("rst_period", int'(period_a), 0);
        check("rst_high_time", int'(high_time_a), 0);
        check("rst_valid", int'(valid_a), 0);
        check("rst_timeout", int'(timeout_a), 0);
        check("rst_level", int'(level_a), 0);
        rst_n = 1'b1;
        cyc(2);

        // Table-driven square waves.
        for (int v = 0; v < 5; v++) begin
            restart();
            run_wave(vecs[v].hi, vecs[v].lo, vecs[v].n, vecs[v].exp_period, vecs[v].exp_high);
        end

        // Latency from pwm_in rise to valid.
        restart();
        begin
            exp_t e;
            e.period = 6;
            e.high   = 3;
            q_a.push_back(e);
        end
        drive_period(0, 3, 3);
        pwm_a = 1'b1;
        lat_k = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (valid_a && lat_k == 0) lat_k = k;
        end
        check("latency", lat_k, LAT);
        @(negedge clk);
        pwm_a = 1'b0;
        cyc(10);

        // Stuck-high input: timeout exactly TIMEOUT cycles after the qualified rise.
        restart();
        pwm_a = 1'b1;
        for (int k = 1; k <= LAT + 20; k++) begin
            @(posedge clk);
            #1;
            if (k == LAT + 19) check("timeout_before", int'(timeout_a), 0);
            if (k == LAT + 20) check("timeout_at", int'(timeout_a), 1);
        end
        @(negedge clk);
        check("level_high", int'(level_a), 1);
        pwm_a = 1'b0;
        cyc(4);
        check("timeout_sticky", int'(timeout_a), 1);
        run_wave(4, 4, 3, 8, 4);
        check("timeout_cleared", int'(timeout_a), 0);

        // Asynchronous reset mid-high phase.
        restart();
        run_wave(4, 4, 2, 8, 4);
        check("pre_rst_period", int'(period_a), 8);
        pwm_a = 1'b1;
        cyc(3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_period", int'(period_a), 0);
        check("async_rst_high_time", int'(high_time_a), 0);
        check("async_rst_level", int'(level_a), 0);
        check("async_rst_valid", int'(valid_a), 0);
        @(negedge clk);
        pwm_a = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(6);
        run_wave(4, 4, 1, 8, 4);

        // Enable dropped for 5 cycles while in LOW.
        restart();
        run_wave(4, 4, 2, 8, 4);
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("ena_off_valid", int'(valid_a), 0);
            check("ena_off_period", int'(period_a), 8);
            check("ena_off_high", int'(high_time_a), 4);
        end
        ena = 1'b1;
        cyc(2);
        run_wave(4, 4, 1, 8, 4);

        // One-cycle glitch every 12 cycles.
        restart();
`ifdef PWM_CAP_GLITCH_FILTER_EN
        run_wave(4, 4, 1, 8, 4);
        repeat (4) drive_period(0, 1, 11);
        check("glitch_timeout", int'(timeout_a), 1);
`else
        run_wave(1, 11, 3, 12, 1);
`endif

        // Narrow counter: period 14 measured, period 16 times out without wrapping.
        restart();
        begin
            exp_t e;
            e.period = 14;
            e.high   = 7;
            for (int i = 0; i < 3; i++) q_b.push_back(e);
        end
        repeat (3) drive_period(1, 7, 7);
        repeat (3) drive_period(1, 8, 8);
        cyc(4);
        check("narrow_timeout", int'(timeout_b), 1);
        check("narrow_period_hold", int'(period_b), 14);
        check("narrow_high_hold", int'(high_time_b), 7);

        cyc(4);
        check("pending_a", q_a.size(), 0);
        check("pending_b", q_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
